picorv32_regs_ctrl: RTL and testbench
=====================================

// Module: picorv32_regs_ctrl
// PURPOSE
//  Sequencer/arbiter in front of the PicoRV32 register file (31x32, x0 not stored).
//  After reset it clears x1..x31 one per cycle. It then passes core traffic through
//  and shares the file with a debug port (req/ack), stalling the core around each access.
// PARAMETERS
//  DW          32   data width
//  AW          6    core register address width (regs index = ~addr[4:0])
//  NREGS       31   stored registers, x1..x31
//  INIT_CLEAR  1    1: run clear sequence after reset; 0: go straight to RUN
//  INIT_VALUE  0    value written during clear (DW bits)
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous reset, active-high
//  core_wen     in   1   core write enable
//  core_waddr   in   AW  core write address
//  core_wdata   in   DW  core write data
//  core_raddr1  in   AW  core read address 1
//  core_raddr2  in   AW  core read address 2
//  core_rdata1  out  DW  read data 1 to core (comb from rf_rdata1)
//  core_rdata2  out  DW  read data 2 to core (comb from rf_rdata2)
//  core_idle    in   1   core quiescent: no wen, no pending reads
//  core_stall   out  1   core must hold; asserted in INIT and during debug access
//  rf_wen       out  1   regfile write enable
//  rf_waddr     out  AW  regfile write address
//  rf_wdata     out  DW  regfile write data
//  rf_raddr1    out  AW  regfile read address 1 (always core_raddr1)
//  rf_raddr2    out  AW  regfile read address 2 (core or debug)
//  rf_rdata1    in   DW  regfile read data 1
//  rf_rdata2    in   DW  regfile read data 2
//  dbg_req      in   1   debug request; held until dbg_ack
//  dbg_we       in   1   1 = write, 0 = read; stable while dbg_req
//  dbg_addr     in   5   register number 0..31; stable while dbg_req
//  dbg_wdata    in   DW  debug write data; stable while dbg_req
//  dbg_ack      out  1   one-cycle completion pulse
//  dbg_rdata    out  DW  read result, valid with dbg_ack, held until next ack
//  init_done    out  1   clear sequence finished (sticky until reset)
// BEHAVIOUR
//  Reset values: state=INIT (RUN if !INIT_CLEAR), clr_cnt=1, core_stall=INIT_CLEAR,
//   dbg_ack=0, dbg_rdata=0, init_done=!INIT_CLEAR, all rf_* write outputs 0.
//  rf_wen/rf_waddr/rf_wdata/rf_raddr2 are combinational muxes of the registered state.
//  States:
//  - INIT: rf_wen=1, rf_waddr=clr_cnt, rf_wdata=INIT_VALUE; clr_cnt 1..NREGS, one/cycle.
//    After addr NREGS is written: init_done=1, go to RUN. Takes exactly NREGS cycles.
//    core_stall=1; core_wen ignored; dbg_req left pending.
//  - RUN: rf_* = core_*; core_stall=0. If dbg_req: core_stall=1 next cycle, go to DRAIN.
//  - DRAIN: core_stall=1; rf_* still = core_*. Leave to ACCESS in the first cycle core_idle=1.
//    The first core_idle check is one cycle after stall is asserted.
//  - ACCESS: one cycle.
//    Write, addr!=0: rf_wen=1, rf_waddr={1'b0,dbg_addr}, rf_wdata=dbg_wdata.
//    Read: rf_raddr2={1'b0,dbg_addr}; register dbg_rdata=rf_rdata2 (0 if addr==0).
//    Write to addr 0: no rf_wen, still acked.
//  - ACK: dbg_ack=1 for one cycle, core_stall=1, rf_* = core_*.
//    Next: DRAIN if dbg_req is re-asserted (new request seen the cycle after ack), else RUN.
//  Latency: dbg_req rise -> dbg_ack is 4 cycles minimum (RUN, DRAIN, ACCESS, ACK).
//  Core stall is released the cycle after ACK.
//  Debug write then core read of the same reg: the core sees new data (write commits in ACCESS).
//  core_wen in DRAIN is still passed through (core finishing in-flight write).
//  core_wen in ACCESS/ACK is a protocol error: dropped.
//  rst asserted mid-operation: immediate return to reset values, and INIT restarts.
//  An in-flight debug access is abandoned with no ack.
//  clr_cnt is $clog2(NREGS+1) bits wide; it does not wrap and stops at NREGS.
// STRUCTURE
//  Package picorv32_regs_pkg: typedef enum {INIT,RUN,DRAIN,ACCESS,ACK} rf_ctrl_state_e;
//   localparams RF_DW, RF_AW, RF_NREGS.
//  Single module, no sub-modules. Instantiated between picorv32 core and picorv32_regs.
// TESTING
//  1 Reset release, INIT_CLEAR=1 -> rf_wen 31 cycles, addr 1..31, data 0; init_done on cycle 32.
//    Every reg then reads 0.
//  2 Core writes x5=0xDEADBEEF in RUN -> rf_wen the same cycle.
//    core_raddr1=5 next cycle -> core_rdata1=0xDEADBEEF.
//  3 dbg_req read x5, core_idle=1 -> dbg_ack 4 cycles after req, dbg_rdata=0xDEADBEEF.
//    core_stall high for 3 cycles.
//  4 Debug write x31=0x12345678 with core_idle held 0 for 5 cycles -> no rf_wen until idle.
//    Then write in ACCESS and ack; the core then reads 0x12345678.
//  5 Debug write to x0 -> no rf_wen, dbg_ack=1; debug read x0 -> dbg_rdata=0.
//  6 rst pulse during DRAIN and again mid-INIT (clr_cnt=10) -> no dbg_ack.
//    INIT restarts from addr 1; full 31-cycle clear repeats.

Source files
------------

// File: rtl/picorv32_regs_pkg.sv
// Shared types and sizes for the PicoRV32 register-file sequencer.
// Imported by the debug interface and the controller.
package picorv32_regs_pkg;

  localparam int RF_DW    = 32;
  localparam int RF_AW    = 6;
  localparam int RF_NREGS = 31;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    DRAIN,
    ACCESS,
    ACK
  } rf_ctrl_state_e;

endpackage

// File: rtl/picorv32_regs_ctrl_if.sv
// Debug access port of the register-file sequencer.
// Request is held with stable fields until a one-cycle ack.
interface picorv32_regs_ctrl_if
  import picorv32_regs_pkg::*;
#(
  parameter int DW = RF_DW
);

  logic          dbg_req;
  logic          dbg_we;
  logic [4:0]    dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_ack;
  logic [DW-1:0] dbg_rdata;

  modport master (
    output dbg_req,
    output dbg_we,
    output dbg_addr,
    output dbg_wdata,
    input  dbg_ack,
    input  dbg_rdata
  );

  modport slave (
    input  dbg_req,
    input  dbg_we,
    input  dbg_addr,
    input  dbg_wdata,
    output dbg_ack,
    output dbg_rdata
  );

endinterface

// File: rtl/picorv32_regs_ctrl.sv
// Register-file sequencer: clears x1..x31 after reset, then
// passes core traffic and slots in debug accesses with a stall.
module picorv32_regs_ctrl
  import picorv32_regs_pkg::*;
#(
  parameter int            DW         = RF_DW,
  parameter int            AW         = RF_AW,
  parameter int            NREGS      = RF_NREGS,
  parameter bit            INIT_CLEAR = 1'b1,
  parameter logic [DW-1:0] INIT_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_wen,
  input  logic [AW-1:0] core_waddr,
  input  logic [DW-1:0] core_wdata,
  input  logic [AW-1:0] core_raddr1,
  input  logic [AW-1:0] core_raddr2,
  output logic [DW-1:0] core_rdata1,
  output logic [DW-1:0] core_rdata2,
  input  logic          core_idle,
  output logic          core_stall,
  output logic          rf_wen,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [AW-1:0] rf_raddr1,
  output logic [AW-1:0] rf_raddr2,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  picorv32_regs_ctrl_if.slave dbg,
  output logic          init_done
);

  localparam int CW = $clog2(NREGS + 1);
  localparam logic [CW-1:0] LAST = CW'(NREGS);
  localparam rf_ctrl_state_e RST_ST =
    INIT_CLEAR ? INIT : RUN;

  rf_ctrl_state_e r_state;
  logic [CW-1:0]  r_clr_cnt;
  logic           r_stall;
  logic           r_ack;
  logic [DW-1:0]  r_rdata;
  logic           r_init_done;

  logic [AW-1:0]  w_dbg_addr;
  logic           w_dbg_wr;
  logic           w_dbg_x0;

  assign w_dbg_addr = AW'(dbg.dbg_addr);
  assign w_dbg_x0   = (dbg.dbg_addr == 5'd0);
  assign w_dbg_wr   = dbg.dbg_we && !w_dbg_x0;

  assign rf_raddr1     = core_raddr1;
  assign core_rdata1   = rf_rdata1;
  assign core_rdata2   = rf_rdata2;
  assign core_stall    = r_stall;
  assign dbg.dbg_ack   = r_ack;
  assign dbg.dbg_rdata = r_rdata;
  assign init_done     = r_init_done;

  // Sequencer: clear walk, pass-through, drain, debug slot, ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RST_ST;
      r_clr_cnt   <= CW'(1);
      r_stall     <= INIT_CLEAR;
      r_ack       <= 1'b0;
      r_rdata     <= '0;
      r_init_done <= !INIT_CLEAR;
    end else begin
      r_ack <= 1'b0;
      unique case (r_state)
        INIT: begin
          if (r_clr_cnt == LAST) begin
            r_state     <= RUN;
            r_stall     <= 1'b0;
            r_init_done <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + CW'(1);
          end
        end
        RUN: begin
          if (dbg.dbg_req) begin
            r_state <= DRAIN;
            r_stall <= 1'b1;
          end
        end
        DRAIN: begin
          if (core_idle) r_state <= ACCESS;
        end
        ACCESS: begin
          r_state <= ACK;
          r_ack   <= 1'b1;
          if (!dbg.dbg_we)
            r_rdata <= w_dbg_x0 ? '0 : rf_rdata2;
        end
        ACK: begin
          if (dbg.dbg_req) begin
            r_state <= DRAIN;
          end else begin
            r_state <= RUN;
            r_stall <= 1'b0;
          end
        end
        default: begin
          r_state <= RST_ST;
          r_stall <= INIT_CLEAR;
        end
      endcase
    end
  end

  // Regfile port mux; core writes are dropped in ACCESS/ACK.
  always_comb begin
    rf_wen    = 1'b0;
    rf_waddr  = core_waddr;
    rf_wdata  = core_wdata;
    rf_raddr2 = core_raddr2;
    unique case (r_state)
      INIT: begin
        rf_wen   = 1'b1;
        rf_waddr = AW'(r_clr_cnt);
        rf_wdata = INIT_VALUE;
      end
      RUN, DRAIN: begin
        rf_wen = core_wen;
      end
      ACCESS: begin
        rf_wen    = w_dbg_wr;
        rf_waddr  = w_dbg_addr;
        rf_wdata  = dbg.dbg_wdata;
        rf_raddr2 = w_dbg_addr;
      end
      default: begin
        rf_wen = 1'b0;
      end
    endcase
    if (rst) begin
      rf_wen   = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
    end
  end

endmodule

// File: tb/tb_picorv32_regs_ctrl.sv
// Bench for picorv32_regs_ctrl: regfile environment, behavioural
// reference model, per-cycle compare, directed and random traffic.
module tb_picorv32_regs_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_wen;
  logic [5:0]  core_waddr;
  logic [31:0] core_wdata;
  logic [5:0]  core_raddr1;
  logic [5:0]  core_raddr2;
  logic [31:0] core_rdata1;
  logic [31:0] core_rdata2;
  logic        core_idle;
  logic        core_stall;
  logic        rf_wen;
  logic [5:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [5:0]  rf_raddr1;
  logic [5:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        init_done;

  int checks = 0;
  int errors = 0;

  picorv32_regs_ctrl_if #(.DW(32)) dbg ();

  picorv32_regs_ctrl #(
    .INIT_CLEAR(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .core_wen   (core_wen),
    .core_waddr (core_waddr),
    .core_wdata (core_wdata),
    .core_raddr1(core_raddr1),
    .core_raddr2(core_raddr2),
    .core_rdata1(core_rdata1),
    .core_rdata2(core_rdata2),
    .core_idle  (core_idle),
    .core_stall (core_stall),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .dbg        (dbg),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s got=%0h want=%0h t=%0t",
                 nm, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s wait bound expired t=%0t", nm, $time);
  endtask

  // Regfile environment; scrambled on every reset cycle.
  logic [31:0] mem [32];
  assign rf_rdata1 = (rf_raddr1[4:0] == 5'd0) ? 32'd0
                   : mem[rf_raddr1[4:0]];
  assign rf_rdata2 = (rf_raddr2[4:0] == 5'd0) ? 32'd0
                   : mem[rf_raddr2[4:0]];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < 32; i++) mem[i] <= $urandom;
    end else if (rf_wen) begin
      mem[rf_waddr[4:0]] <= rf_wdata;
    end
  end

  // Reference model: expected register contents and debug progress.
  logic [31:0] mdl [32];
  int          clr_pos;
  bit          busy;
  int          step;
  logic [31:0] m_rdata;

  function automatic logic [31:0] mrd(input logic [5:0] a);
    return (a[4:0] == 5'd0) ? 32'd0 : mdl[a[4:0]];
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      clr_pos <= 1;
      busy    <= 1'b0;
      step    <= 0;
      m_rdata <= 32'd0;
    end else if (clr_pos <= 31) begin
      mdl[clr_pos] <= 32'd0;
      clr_pos      <= clr_pos + 1;
    end else if (!busy || step == 0) begin
      if (core_wen && core_waddr[4:0] != 5'd0)
        mdl[core_waddr[4:0]] <= core_wdata;
      if (!busy && dbg.dbg_req) begin
        busy <= 1'b1;
        step <= 0;
      end
      if (busy && core_idle) step <= 1;
    end else if (step == 1) begin
      if (dbg.dbg_we) begin
        if (dbg.dbg_addr != 5'd0)
          mdl[dbg.dbg_addr] <= dbg.dbg_wdata;
      end else begin
        m_rdata <= mrd({1'b0, dbg.dbg_addr});
      end
      step <= 2;
    end else begin
      if (dbg.dbg_req) step <= 0;
      else busy <= 1'b0;
    end
  end

  logic        e_clr;
  logic        e_stall;
  logic        e_wen;
  logic [5:0]  e_waddr;
  logic [31:0] e_wdata;
  logic [5:0]  e_ra2;

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_stall", core_stall, 1);
      chk("rst_ack", dbg.dbg_ack, 0);
      chk("rst_rdata", dbg.dbg_rdata, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_wen", rf_wen, 0);
      chk("rst_waddr", rf_waddr, 0);
      chk("rst_wdata", rf_wdata, 0);
    end else begin
      e_clr   = (clr_pos <= 31);
      e_stall = e_clr || busy;
      e_wen   = core_wen;
      e_waddr = core_waddr;
      e_wdata = core_wdata;
      e_ra2   = core_raddr2;
      if (e_clr) begin
        e_wen   = 1'b1;
        e_waddr = 6'(clr_pos);
        e_wdata = 32'd0;
      end else if (busy && step == 1) begin
        e_wen   = dbg.dbg_we && dbg.dbg_addr != 5'd0;
        e_waddr = {1'b0, dbg.dbg_addr};
        e_wdata = dbg.dbg_wdata;
        e_ra2   = {1'b0, dbg.dbg_addr};
      end else if (busy && step == 2) begin
        e_wen = 1'b0;
      end
      chk("stall", core_stall, e_stall);
      chk("ack", dbg.dbg_ack, busy && step == 2);
      chk("init_done", init_done, !e_clr);
      chk("rf_wen", rf_wen, e_wen);
      if (e_wen) begin
        chk("rf_waddr", rf_waddr, e_waddr);
        chk("rf_wdata", rf_wdata, e_wdata);
      end
      chk("rf_raddr1", rf_raddr1, core_raddr1);
      chk("rf_raddr2", rf_raddr2, e_ra2);
      chk("dbg_rdata", dbg.dbg_rdata, m_rdata);
      if (!e_clr)
        chk("core_rdata1", core_rdata1, mrd(core_raddr1));
      if (!e_stall)
        chk("core_rdata2", core_rdata2, mrd(core_raddr2));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic init_seq(input string tag);
    int wens;
    int bad;
    int done_at;
    wens    = 0;
    bad     = 0;
    done_at = 0;
    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      @(negedge clk);
      if (init_done) begin
        done_at = i;
      end else if (rf_wen) begin
        wens++;
        if (rf_waddr != 6'(i) || rf_wdata != 32'd0) bad++;
      end
      tick();
    end
    chk({tag, "_clear_wens"}, wens, 31);
    chk({tag, "_done_cycle"}, done_at, 32);
    chk({tag, "_clear_seq_bad"}, bad, 0);
  endtask

  task automatic dbg_xfer(input  logic        we,
                          input  logic [4:0]  a,
                          input  logic [31:0] d,
                          input  int          idle_hold,
                          output int          lat,
                          output int          stl,
                          output int          wen_n,
                          output int          wen_at,
                          output logic [31:0] rd);
    lat    = 0;
    stl    = 0;
    wen_n  = 0;
    wen_at = 0;
    rd     = 32'd0;
    dbg.dbg_req   = 1'b1;
    dbg.dbg_we    = we;
    dbg.dbg_addr  = a;
    dbg.dbg_wdata = d;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      core_idle = (c > idle_hold);
      @(negedge clk);
      if (core_stall) stl++;
      if (rf_wen) begin
        wen_n++;
        wen_at = c;
      end
      if (dbg.dbg_ack) begin
        lat         = c;
        rd          = dbg.dbg_rdata;
        dbg.dbg_req = 1'b0;
      end
      tick();
    end
    core_idle = 1'b1;
    if (lat == 0) begin
      dbg.dbg_req = 1'b0;
      bound_fail("dbg_xfer");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1);
  end

  initial begin
    int          lat;
    int          stl;
    int          wn;
    int          wat;
    int          acks;
    int          hold;
    logic [31:0] rd;

    rst           = 1'b1;
    core_wen      = 1'b0;
    core_waddr    = '0;
    core_wdata    = '0;
    core_raddr1   = '0;
    core_raddr2   = '0;
    core_idle     = 1'b1;
    dbg.dbg_req   = 1'b0;
    dbg.dbg_we    = 1'b0;
    dbg.dbg_addr  = '0;
    dbg.dbg_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Clear walk after reset, then every register reads zero.
    init_seq("t1");
    for (int r = 1; r < 32; r++) begin
      core_raddr1 = 6'(r);
      @(negedge clk);
      chk("t1_read_zero", core_rdata1, 32'd0);
      tick();
    end

    // Core write passes straight through and is readable.
    core_wen   = 1'b1;
    core_waddr = 6'd5;
    core_wdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_wen", rf_wen, 1);
    chk("t2_waddr", rf_waddr, 5);
    tick();
    core_wen    = 1'b0;
    core_raddr1 = 6'd5;
    @(negedge clk);
    chk("t2_rdata1", core_rdata1, 32'hDEADBEEF);
    tick();

    // Debug read with an idle core.
    dbg_xfer(1'b0, 5'd5, 32'd0, 0, lat, stl, wn, wat, rd);
    chk("t3_latency", lat, 4);
    chk("t3_stall_cycles", stl, 3);
    chk("t3_rdata", rd, 32'hDEADBEEF);
    @(negedge clk);
    chk("t3_stall_released", core_stall, 0);
    tick();

    // Debug write waits for the core to go idle.
    dbg_xfer(1'b1, 5'd31, 32'h12345678, 5, lat, stl, wn, wat, rd);
    chk("t4_latency", lat, 8);
    chk("t4_wen_count", wn, 1);
    chk("t4_wen_cycle", wat, 7);
    chk("t4_stall_cycles", stl, 7);
    core_raddr1 = 6'd31;
    @(negedge clk);
    chk("t4_core_read", core_rdata1, 32'h12345678);
    tick();

    // x0 accesses: write is dropped but acked, read gives zero.
    dbg_xfer(1'b1, 5'd0, 32'hFFFF_FFFF, 0, lat, stl, wn, wat, rd);
    chk("t5_wr0_wens", wn, 0);
    chk("t5_wr0_latency", lat, 4);
    chk("t5_wr0_rdata_held", rd, 32'hDEADBEEF);
    dbg_xfer(1'b0, 5'd0, 32'd0, 0, lat, stl, wn, wat, rd);
    chk("t5_rd0_rdata", rd, 32'd0);
    tick();

    // Reset in DRAIN and again mid-clear abandons the access.
    acks          = 0;
    dbg.dbg_req   = 1'b1;
    dbg.dbg_we    = 1'b0;
    dbg.dbg_addr  = 5'd5;
    core_idle     = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acks += int'(dbg.dbg_ack);
      tick();
    end
    chk("t6_stall_in_drain", core_stall, 1);
    rst         = 1'b1;
    dbg.dbg_req = 1'b0;
    core_idle   = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (9) begin
      @(negedge clk);
      acks += int'(dbg.dbg_ack);
      tick();
    end
    chk("t6_mid_clear_addr", rf_waddr, 10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    init_seq("t6");
    chk("t6_no_ack", acks, 0);

    // Random traffic against the model, with back-to-back requests
    // and occasional resets.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(599, 0) == 0) begin
        rst         = 1'b1;
        dbg.dbg_req = 1'b0;
        hold        = 0;
        tick();
        rst = 1'b0;
      end
      core_wen    = ($urandom_range(2, 0) == 0);
      core_waddr  = 6'($urandom_range(31, 0));
      core_wdata  = $urandom;
      core_raddr1 = 6'($urandom_range(31, 0));
      core_raddr2 = 6'($urandom_range(31, 0));
      core_idle   = ($urandom_range(3, 0) != 0);
      if (!dbg.dbg_req && $urandom_range(5, 0) == 0) begin
        dbg.dbg_req   = 1'b1;
        dbg.dbg_we    = 1'($urandom_range(1, 0));
        dbg.dbg_addr  = 5'($urandom_range(31, 0));
        dbg.dbg_wdata = $urandom;
        hold          = 0;
      end
      @(negedge clk);
      if (dbg.dbg_req && dbg.dbg_ack) begin
        hold = 0;
        if ($urandom_range(3, 0) == 0) begin
          dbg.dbg_we    = 1'($urandom_range(1, 0));
          dbg.dbg_addr  = 5'($urandom_range(31, 0));
          dbg.dbg_wdata = $urandom;
        end else begin
          dbg.dbg_req = 1'b0;
        end
      end else if (dbg.dbg_req) begin
        hold++;
        if (hold > 200) begin
          bound_fail("rand_dbg_ack");
          dbg.dbg_req = 1'b0;
          hold        = 0;
        end
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
